// File: rtl/vca_pwmdac_multi_if.sv
// Bundles the per-channel target/mode inputs and the DAC-side outputs of vca_pwmdac_multi.
//   in_data     : CHANNELS*WIDTH targets, channel c at [c*WIDTH +: WIDTH]
//   mode        : 0 = PWM, 1 = sigma-delta (takes effect at the next period boundary)
//   sout        : per-channel 1-bit DAC outputs
//   settled     : per-channel "level equals target" flags
//   period_tick : one-clock pulse following each period boundary
// master = voice/envelope side, slave = the DAC block.
interface vca_pwmdac_multi_if #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned CHANNELS = 4
);
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic                      mode;
   logic [CHANNELS-1:0]       sout;
   logic [CHANNELS-1:0]       settled;
   logic                      period_tick;

   modport master (
      output in_data,
      output mode,
      input  sout,
      input  settled,
      input  period_tick
   );

   modport slave (
      input  in_data,
      input  mode,
      output sout,
      output settled,
      output period_tick
   );
endinterface

// File: rtl/vca_pwmdac_multi.sv
// Multi-channel slew-limited 1-bit DAC for VCA/CV outputs.
// Each channel's level walks toward its target by at most SLEW_STEP per 2^WIDTH-clock period and
// is rendered either as PWM (level > cnt) or as a first-order sigma-delta carry stream.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of vca_pwmdac_multi_if (in_data, mode in; sout, settled, period_tick out)
module vca_pwmdac_multi #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned CHANNELS  = 4,
   parameter int unsigned SLEW_STEP = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   vca_pwmdac_multi_if.slave   bus
);

   localparam logic [WIDTH:0] Step = (WIDTH+1)'(SLEW_STEP);

   logic [WIDTH-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0]    level_q [CHANNELS];
   logic [WIDTH-1:0]    level_d [CHANNELS];
   logic [WIDTH-1:0]    acc_q   [CHANNELS];
   logic [WIDTH-1:0]    acc_d   [CHANNELS];
   logic                mode_q, mode_d;
   logic [CHANNELS-1:0] sout_q, sout_d;
   logic [CHANNELS-1:0] settled_q, settled_d;
   logic                tick_q, tick_d;

   logic                boundary;
   logic                mode_flip;
   logic [WIDTH-1:0]    target [CHANNELS];
   logic [WIDTH:0]      sum    [CHANNELS];
   logic [WIDTH:0]      up     [CHANNELS];
   logic [WIDTH:0]      dn     [CHANNELS];

   always_comb begin
      boundary  = (cnt_q == '0);
      mode_flip = boundary && (bus.mode != mode_q);
      cnt_d     = cnt_q + 1'b1;
      tick_d    = boundary;
      mode_d    = boundary ? bus.mode : mode_q;
      sout_d    = '0;
      settled_d = '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         target[c] = bus.in_data[c*WIDTH +: WIDTH];
         sum[c]    = {1'b0, acc_q[c]} + {1'b0, level_q[c]};
         up[c]     = {1'b0, target[c]} - {1'b0, level_q[c]};
         dn[c]     = {1'b0, level_q[c]} - {1'b0, target[c]};

         // Output uses the mode in force before this edge; a new mode starts next cycle.
         sout_d[c]    = mode_q ? sum[c][WIDTH] : (level_q[c] > cnt_q);
         settled_d[c] = (level_q[c] == target[c]);

         // Accumulators only run in sigma-delta and restart from 0 on any mode switch.
         acc_d[c] = acc_q[c];
         if (mode_flip) begin
            acc_d[c] = '0;
         end else if (mode_q) begin
            acc_d[c] = sum[c][WIDTH-1:0];
         end

         // Step toward the target; a remaining distance <= Step lands exactly on it.
         level_d[c] = level_q[c];
         if (boundary) begin
            if (SLEW_STEP == 0) begin
               level_d[c] = target[c];
            end else if (target[c] > level_q[c]) begin
               level_d[c] = (up[c] > Step) ? level_q[c] + Step[WIDTH-1:0] : target[c];
            end else if (target[c] < level_q[c]) begin
               level_d[c] = (dn[c] > Step) ? level_q[c] - Step[WIDTH-1:0] : target[c];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         mode_q    <= 1'b0;
         sout_q    <= '0;
         settled_q <= '0;
         tick_q    <= 1'b0;
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            level_q[c] <= '0;
            acc_q[c]   <= '0;
         end
      end else begin
         cnt_q     <= cnt_d;
         mode_q    <= mode_d;
         sout_q    <= sout_d;
         settled_q <= settled_d;
         tick_q    <= tick_d;
         for (int unsigned c = 0; c < CHANNELS; c++) begin
            level_q[c] <= level_d[c];
            acc_q[c]   <= acc_d[c];
         end
      end
   end

   assign bus.sout        = sout_q;
   assign bus.settled     = settled_q;
   assign bus.period_tick = tick_q;

endmodule

// File: tb/tb_vca_pwmdac_multi.sv
// Bench for vca_pwmdac_multi: three instances (SLEW_STEP = 1, 4, 0) share one stimulus and are
// each compared every cycle against a behavioural model, plus literal duty/timing expectations.
module tb_vca_pwmdac_multi;

   localparam int W   = 8;
   localparam int CH  = 4;
   localparam int ND  = 3;
   localparam int PER = 256;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [CH*W-1:0] in_data = '0;
   logic            mode = 1'b0;

   logic [CH-1:0]   sout_w [ND];
   logic [CH-1:0]   set_w  [ND];
   logic            tick_w [ND];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   function automatic int step_of(input int g);
      case (g)
         0:       return 1;
         1:       return 4;
         default: return 0;
      endcase
   endfunction

   for (genvar g = 0; g < ND; g++) begin : g_dut
      localparam int unsigned SS = (g == 0) ? 1 : ((g == 1) ? 4 : 0);
      vca_pwmdac_multi_if #(.WIDTH(W), .CHANNELS(CH)) bus ();
      assign bus.in_data = in_data;
      assign bus.mode    = mode;
      assign sout_w[g]   = bus.sout;
      assign set_w[g]    = bus.settled;
      assign tick_w[g]   = bus.period_tick;
      vca_pwmdac_multi #(.WIDTH(W), .CHANNELS(CH), .SLEW_STEP(SS)) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_cnt, m_modeq, m_tick;
   int m_lvl  [ND][CH];
   int m_acc  [ND][CH];
   int m_sout [ND][CH];
   int m_set  [ND][CH];

   task automatic model_reset();
      m_cnt = 0; m_modeq = 0; m_tick = 0;
      for (int g = 0; g < ND; g++)
         for (int c = 0; c < CH; c++) begin
            m_lvl[g][c] = 0; m_acc[g][c] = 0; m_sout[g][c] = 0; m_set[g][c] = 0;
         end
   endtask

   task automatic model_step();
      int tgt, lv, s;
      bit bnd;
      bnd = (m_cnt == 0);
      for (int g = 0; g < ND; g++)
         for (int c = 0; c < CH; c++) begin
            tgt = int'(in_data[c*W +: W]);
            lv  = m_lvl[g][c];
            if (m_modeq == 0) m_sout[g][c] = (lv > m_cnt) ? 1 : 0;
            else              m_sout[g][c] = (m_acc[g][c] + lv >= PER) ? 1 : 0;
            if (bnd && int'(mode) != m_modeq) m_acc[g][c] = 0;
            else if (m_modeq == 1)            m_acc[g][c] = (m_acc[g][c] + lv) % PER;
            m_set[g][c] = (lv == tgt) ? 1 : 0;
            if (bnd) begin
               s = step_of(g);
               if (s == 0)        lv = tgt;
               else if (tgt > lv) lv = lv + ((tgt - lv < s) ? tgt - lv : s);
               else if (tgt < lv) lv = lv - ((lv - tgt < s) ? lv - tgt : s);
               m_lvl[g][c] = lv;
            end
         end
      m_tick = bnd ? 1 : 0;
      if (bnd) m_modeq = int'(mode);
      m_cnt = (m_cnt + 1) % PER;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else        model_step();
      end
   end

   // Every-cycle comparison against the model.
   initial begin
      logic [CH-1:0] es, ee;
      forever begin
         @(negedge clk);
         for (int g = 0; g < ND; g++) begin
            for (int c = 0; c < CH; c++) begin
               es[c] = m_sout[g][c][0];
               ee[c] = m_set[g][c][0];
            end
            check($sformatf("sout[dut%0d]", g), int'(sout_w[g]), int'(es));
            check($sformatf("settled[dut%0d]", g), int'(set_w[g]), int'(ee));
            check($sformatf("tick[dut%0d]", g), int'(tick_w[g]), m_tick);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_tgt(input int c, input int v);
      in_data[c*W +: W] = v[W-1:0];
   endtask

   task automatic wait_tick(input int g);
      bit found;
      found = 0;
      for (int i = 0; i < 600 && !found; i++) begin
         @(negedge clk);
         if (tick_w[g]) found = 1;
      end
      if (!found) check("tick_timeout", 0, 1);
   endtask

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) wait_tick(0);
   endtask

   task automatic count_win(input int g, input int c, output int ones, output int trans);
      logic prev;
      ones = 0; trans = 0; prev = sout_w[g][c];
      for (int i = 0; i < PER; i++) begin
         @(negedge clk);
         ones += int'(sout_w[g][c]);
         if (i > 0 && sout_w[g][c] != prev) trans++;
         prev = sout_w[g][c];
      end
   endtask

   initial begin
      int ones, trans;
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int ones, trans;
      set_tgt(0, 64); set_tgt(1, 255); set_tgt(2, 10); set_tgt(3, 0);
      mode = 1'b0;
      repeat (3) @(negedge clk);
      for (int g = 0; g < ND; g++) begin
         check("reset_sout", int'(sout_w[g]), 0);
         check("reset_tick", int'(tick_w[g]), 0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      for (int g = 0; g < ND; g++) check("first_tick", int'(tick_w[g]), 1);

      // Ramp ch0 (step 1) to level 30, then reset mid-period.
      wait_ticks(29);
      repeat (100) @(negedge clk);
      check("model_lvl30", m_lvl[0][0], 30);
      check("ramp_unsettled", int'(set_w[0][0]), 0);
      check("step4_settled10", int'(set_w[1][2]), 1);
      check("step0_settled255", int'(set_w[2][1]), 1);
      #2 rst_n = 1'b0;
      #1;
      for (int g = 0; g < ND; g++) begin
         check("async_sout", int'(sout_w[g]), 0);
         check("async_settled", int'(set_w[g]), 0);
         check("async_tick", int'(tick_w[g]), 0);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int g = 0; g < ND; g++) check("tick_after_reset", int'(tick_w[g]), 1);
      check("model_lvl_restart", m_lvl[0][0], 1);

      // Ramp to 64 completes after 64 boundaries.
      wait_ticks(66);
      check("ramp_settled", int'(set_w[0][0]), 1);
      count_win(0, 0, ones, trans);
      check("pwm64_ones", ones, 64);
      count_win(0, 3, ones, trans);
      check("pwm0_ones", ones, 0);
      count_win(2, 1, ones, trans);
      check("pwm255_ones", ones, 255);

      // Step-4 ramp back down from 10 to 3: 6 then 3.
      repeat (37) @(negedge clk);
      set_tgt(2, 3);
      wait_tick(1);
      check("down_unsettled_a", int'(set_w[1][2]), 0);
      check("model_lvl6", m_lvl[1][2], 6);
      wait_tick(1);
      check("down_unsettled_b", int'(set_w[1][2]), 0);
      @(negedge clk);
      check("down_settled", int'(set_w[1][2]), 1);

      // Sigma-delta, switched mid-period.
      wait_tick(0);
      repeat (50) @(negedge clk);
      mode = 1'b1;
      set_tgt(0, 128);
      wait_ticks(2);
      count_win(2, 0, ones, trans);
      check("sd128_ones", ones, 128);
      check("sd128_alternate", trans, 255);
      repeat (20) @(negedge clk);
      set_tgt(0, 64);
      wait_ticks(2);
      count_win(2, 0, ones, trans);
      check("sd64_ones", ones, 64);
      repeat (20) @(negedge clk);
      set_tgt(0, 0);
      wait_ticks(2);
      count_win(2, 0, ones, trans);
      check("sd0_ones", ones, 0);

      // Mid-period toggle that reverts before the boundary has no effect.
      repeat (30) @(negedge clk);
      mode = 1'b0;
      repeat (30) @(negedge clk);
      mode = 1'b1;
      wait_tick(0);
      check("model_mode_held", m_modeq, 1);

      // Randomised targets and mode changes, checked by the model every cycle.
      for (int it = 0; it < 40; it++) begin
         repeat ($urandom_range(1, 400)) @(negedge clk);
         for (int c = 0; c < CH; c++) begin
            case ($urandom_range(0, 5))
               0:       set_tgt(c, 0);
               1:       set_tgt(c, 255);
               2, 3:    set_tgt(c, int'($urandom_range(0, 255)));
               default: ;
            endcase
         end
         if ($urandom_range(0, 3) == 0) mode = ~mode;
      end
      repeat (300) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
